// File: rtl/rename_unit.sv
// rename_unit: register-rename stage ahead of the ROB.
// Maps architectural sources through a 32-entry RAT and allocates new
// physical destinations from a 64-entry circular free list. Tags retired
// by the ROB come back through the free port.
// Optional build macro: RENAME_FREE_BYPASS_EN lets an allocation on an empty
// list take a same-cycle freed tag directly.
module rename_unit #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [4:0]  in_rd,
    input  logic        in_wr,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  out_prs1,
    output logic [5:0]  out_prs2,
    output logic [5:0]  out_prd,
    output logic [5:0]  out_prd_old,
    output logic [31:0] out_pc,
    input  logic        free_valid,
    input  logic [5:0]  free_tag,
    output logic [6:0]  fl_count
);

    logic [5:0]  rat_q [ARCH_REGS];
    logic [5:0]  rat_d [ARCH_REGS];
    logic [5:0]  fl_q  [PHYS_REGS];
    logic [5:0]  fl_d  [PHYS_REGS];
    logic [5:0]  head_q, head_d;
    logic [5:0]  tail_q, tail_d;
    logic [6:0]  count_q, count_d;

    logic        out_valid_q, out_valid_d;
    logic [5:0]  out_prs1_q, out_prs1_d;
    logic [5:0]  out_prs2_q, out_prs2_d;
    logic [5:0]  out_prd_q, out_prd_d;
    logic [5:0]  out_prd_old_q, out_prd_old_d;
    logic [31:0] out_pc_q, out_pc_d;

    logic        needs_tag;
    logic        free_ok;
    logic        slot_free;
    logic        list_empty;
    logic        bypass;
    logic        use_bypass;
    logic        xfer;
    logic        alloc;
    logic [5:0]  new_tag;

    // Handshake: stall only when the output slot is busy or a needed tag is unavailable
    always_comb begin
        needs_tag  = in_wr && (in_rd != 5'd0);
        free_ok    = free_valid && (free_tag != 6'd0);
        slot_free  = !out_valid_q || out_ready;
        list_empty = (count_q == 7'd0);
`ifdef RENAME_FREE_BYPASS_EN
        bypass     = list_empty && free_ok;
`else
        bypass     = 1'b0;
`endif
        in_ready   = slot_free && (!list_empty || !needs_tag || bypass);
        xfer       = in_valid && in_ready;
        alloc      = xfer && needs_tag;
        // An allocation on an empty list can only happen through the bypass
        use_bypass = alloc && bypass;
        new_tag    = use_bypass ? free_tag : fl_q[head_q];
    end

    // RAT and free-list next state
    always_comb begin
        rat_d   = rat_q;
        fl_d    = fl_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (alloc) begin
            rat_d[in_rd] = new_tag;
        end
        if (!use_bypass) begin
            if (free_ok) begin
                fl_d[tail_q] = free_tag;
                tail_d       = tail_q + 6'd1;
            end
            if (alloc) begin
                head_d = head_q + 6'd1;
            end
            count_d = count_q + {6'd0, free_ok} - {6'd0, alloc};
        end
    end

    // Output register: load on transfer, drop when drained, hold while stalled
    always_comb begin
        out_valid_d   = out_valid_q;
        out_prs1_d    = out_prs1_q;
        out_prs2_d    = out_prs2_q;
        out_prd_d     = out_prd_q;
        out_prd_old_d = out_prd_old_q;
        out_pc_d      = out_pc_q;
        if (xfer) begin
            out_valid_d   = 1'b1;
            out_prs1_d    = (in_rs1 == 5'd0) ? '0 : rat_q[in_rs1];
            out_prs2_d    = (in_rs2 == 5'd0) ? '0 : rat_q[in_rs2];
            out_prd_d     = alloc ? new_tag : '0;
            out_prd_old_d = alloc ? rat_q[in_rd] : '0;
            out_pc_d      = in_pc;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset to identity RAT and tags 32..63 free
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < ARCH_REGS; i++) begin
                rat_q[i] <= 6'(i);
            end
            for (int unsigned i = 0; i < PHYS_REGS; i++) begin
                fl_q[i] <= 6'(i + ARCH_REGS);
            end
            head_q        <= '0;
            tail_q        <= 6'(ARCH_REGS);
            count_q       <= 7'(ARCH_REGS);
            out_valid_q   <= 1'b0;
            out_prs1_q    <= '0;
            out_prs2_q    <= '0;
            out_prd_q     <= '0;
            out_prd_old_q <= '0;
            out_pc_q      <= '0;
        end else begin
            rat_q         <= rat_d;
            fl_q          <= fl_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            out_valid_q   <= out_valid_d;
            out_prs1_q    <= out_prs1_d;
            out_prs2_q    <= out_prs2_d;
            out_prd_q     <= out_prd_d;
            out_prd_old_q <= out_prd_old_d;
            out_pc_q      <= out_pc_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_prs1    = out_prs1_q;
    assign out_prs2    = out_prs2_q;
    assign out_prd     = out_prd_q;
    assign out_prd_old = out_prd_old_q;
    assign out_pc      = out_pc_q;
    assign fl_count    = count_q;

endmodule

// File: tb/tb_rename_unit.sv
// tb_rename_unit: scoreboard bench for rename_unit with a queue-based
// RAT/free-list model. Honors RENAME_FREE_BYPASS_EN when defined.
module tb_rename_unit;

    typedef struct packed {
        logic [5:0]  prs1;
        logic [5:0]  prs2;
        logic [5:0]  prd;
        logic [5:0]  prd_old;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_wr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_prs1, out_prs2, out_prd, out_prd_old;
    logic [31:0] out_pc;
    logic        free_valid;
    logic [5:0]  free_tag;
    logic [6:0]  fl_count;

    int n_vec = 0;
    int n_err = 0;

    exp_t        sb[$];
    logic [5:0]  m_rat[32];
    logic [5:0]  m_fl[$];
    logic [5:0]  to_free[$];
    logic [31:0] pc_ctr = 32'h1000;
    bit          last_xfer;

    rename_unit #(.ARCH_REGS(32), .PHYS_REGS(64)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_wr(in_wr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_prs1(out_prs1), .out_prs2(out_prs2), .out_prd(out_prd),
        .out_prd_old(out_prd_old), .out_pc(out_pc),
        .free_valid(free_valid), .free_tag(free_tag), .fl_count(fl_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rat[i] = 6'(i);
        m_fl.delete();
        for (int i = 32; i < 64; i++) m_fl.push_back(6'(i));
        sb.delete();
        to_free.delete();
    endtask

    task automatic set_in(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic wr);
        pc_ctr   = pc_ctr + 32'd4;
        in_valid = v;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_rd    = rd;
        in_wr    = wr;
        in_pc    = pc_ctr;
    endtask

    // One clock: check outputs against scoreboard at negedge, update model, move past posedge
    task automatic tick();
        bit         was_valid, needs, free_ok, byp, exp_rdy, alloc;
        exp_t       e;
        logic [5:0] tag;
        @(negedge clk);
        was_valid = (sb.size() != 0);
        n_vec++;
        if (out_valid !== was_valid) begin
            n_err++;
            $display("FAIL out_valid: got %b expected %b", out_valid, was_valid);
        end
        if (was_valid) begin
            e = sb[0];
            n_vec++;
            if ({out_prs1, out_prs2, out_prd, out_prd_old, out_pc} !== e) begin
                n_err++;
                $display("FAIL out_fields: got prs1=%0d prs2=%0d prd=%0d old=%0d pc=%h expected prs1=%0d prs2=%0d prd=%0d old=%0d pc=%h",
                         out_prs1, out_prs2, out_prd, out_prd_old, out_pc,
                         e.prs1, e.prs2, e.prd, e.prd_old, e.pc);
            end
            if (out_ready) void'(sb.pop_front());
        end
        n_vec++;
        if (fl_count !== 7'(m_fl.size())) begin
            n_err++;
            $display("FAIL fl_count: got %0d expected %0d", fl_count, m_fl.size());
        end
        needs   = in_wr && (in_rd != 5'd0);
        free_ok = free_valid && (free_tag != 6'd0);
        byp     = 1'b0;
`ifdef RENAME_FREE_BYPASS_EN
        byp     = (m_fl.size() == 0) && free_ok;
`endif
        exp_rdy = (!was_valid || out_ready) && (m_fl.size() != 0 || !needs || byp);
        n_vec++;
        if (in_ready !== exp_rdy) begin
            n_err++;
            $display("FAIL in_ready: got %b expected %b", in_ready, exp_rdy);
        end
        last_xfer = 1'b0;
        alloc     = 1'b0;
        if (reset) begin
            model_reset();
        end else begin
            if (in_valid && exp_rdy) begin
                last_xfer = 1'b1;
                alloc     = needs;
                e.prs1    = m_rat[in_rs1];
                e.prs2    = m_rat[in_rs2];
                e.pc      = in_pc;
                e.prd     = '0;
                e.prd_old = '0;
                if (alloc) begin
                    if (byp) tag = free_tag;
                    else     tag = m_fl.pop_front();
                    e.prd        = tag;
                    e.prd_old    = m_rat[in_rd];
                    m_rat[in_rd] = tag;
                    to_free.push_back(e.prd_old);
                end
                sb.push_back(e);
            end
            if (free_ok && !(alloc && byp)) m_fl.push_back(free_tag);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        n_vec++;
        if (out_valid !== 1'b0 || fl_count !== 7'd32 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ctl: got valid=%b count=%0d ready=%b expected 0 32 1",
                     out_valid, fl_count, in_ready);
        end
        n_vec++;
        if ({out_prs1, out_prs2, out_prd, out_prd_old, out_pc} !== 56'd0) begin
            n_err++;
            $display("FAIL reset_outs: got %h expected 0",
                     {out_prs1, out_prs2, out_prd, out_prd_old, out_pc});
        end
    endtask

    task automatic test_basic();
        set_in(1'b1, 5'd1, 5'd2, 5'd5, 1'b1);
        tick();
        n_vec++;
        if ({out_prs1, out_prs2, out_prd, out_prd_old} !== {6'd1, 6'd2, 6'd32, 6'd5} || fl_count !== 7'd31) begin
            n_err++;
            $display("FAIL add_x5: got %0d %0d %0d %0d cnt=%0d expected 1 2 32 5 cnt=31",
                     out_prs1, out_prs2, out_prd, out_prd_old, fl_count);
        end
        set_in(1'b1, 5'd5, 5'd5, 5'd6, 1'b1);
        tick();
        n_vec++;
        if ({out_prs1, out_prs2, out_prd, out_prd_old} !== {6'd32, 6'd32, 6'd33, 6'd6}) begin
            n_err++;
            $display("FAIL back_to_back: got %0d %0d %0d %0d expected 32 32 33 6",
                     out_prs1, out_prs2, out_prd, out_prd_old);
        end
    endtask

    task automatic test_fill();
        for (int k = 0; k < 30; k++) begin
            set_in(1'b1, 5'(k), 5'(k + 3), 5'((k % 31) + 1), 1'b1);
            tick();
        end
        n_vec++;
        if (fl_count !== 7'd0) begin
            n_err++;
            $display("FAIL fill_count: got %0d expected 0", fl_count);
        end
        set_in(1'b1, 5'd1, 5'd2, 5'd7, 1'b1);
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL empty_stall: got in_ready=%b expected 0", in_ready);
        end
        tick();
        set_in(1'b1, 5'd3, 5'd4, 5'd7, 1'b0);
        tick();
        n_vec++;
        if (out_valid !== 1'b1 || out_prd !== 6'd0 || out_prd_old !== 6'd0) begin
            n_err++;
            $display("FAIL nowrite_xfer: got valid=%b prd=%0d old=%0d expected 1 0 0",
                     out_valid, out_prd, out_prd_old);
        end
        set_in(1'b1, 5'd3, 5'd4, 5'd0, 1'b1);
        tick();
        n_vec++;
        if (out_valid !== 1'b1 || out_prd !== 6'd0 || out_prd_old !== 6'd0) begin
            n_err++;
            $display("FAIL rd0_xfer: got valid=%b prd=%0d old=%0d expected 1 0 0",
                     out_valid, out_prd, out_prd_old);
        end
    endtask

    task automatic test_empty_free();
        set_in(1'b1, 5'd5, 5'd0, 5'd9, 1'b1);
        free_valid = 1'b1;
        free_tag   = to_free.pop_front();
        tick();
`ifndef RENAME_FREE_BYPASS_EN
        free_valid = 1'b0;
        tick();
`endif
        free_valid = 1'b0;
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        n_vec++;
        if (out_valid !== 1'b1 || out_prd !== 6'd5 || fl_count !== 7'd0) begin
            n_err++;
            $display("FAIL empty_free: got valid=%b prd=%0d cnt=%0d expected 1 5 0",
                     out_valid, out_prd, fl_count);
        end
    endtask

    task automatic test_hold();
        logic [55:0] snap;
        logic [31:0] new_pc;
        out_ready = 1'b0;
        snap = {out_prs1, out_prs2, out_prd, out_prd_old, out_pc};
        set_in(1'b1, 5'd9, 5'd5, 5'd11, 1'b0);
        new_pc = in_pc;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++;
            if ({out_prs1, out_prs2, out_prd, out_prd_old, out_pc} !== snap || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL hold_stable: got %h ready=%b valid=%b expected %h 0 1",
                         {out_prs1, out_prs2, out_prd, out_prd_old, out_pc}, in_ready, out_valid, snap);
            end
        end
        out_ready = 1'b1;
        tick();
        n_vec++;
        if (out_pc !== new_pc || out_prs1 !== 6'd5) begin
            n_err++;
            $display("FAIL hold_release: got pc=%h prs1=%0d expected pc=%h prs1=5",
                     out_pc, out_prs1, new_pc);
        end
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 4; k++) begin
            free_valid = 1'b1;
            free_tag   = to_free.pop_front();
            tick();
        end
        for (int k = 0; k < 70; k++) begin
            set_in(1'b1, 5'(k % 32), 5'((k + 7) % 32), 5'((k % 31) + 1), 1'b1);
            free_valid = 1'b1;
            free_tag   = to_free.pop_front();
            tick();
            n_vec++;
            if (fl_count !== 7'd4) begin
                n_err++;
                $display("FAIL wrap_count: got %0d expected 4 at pair %0d", fl_count, k);
            end
        end
        free_valid = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b0;
        set_in(1'b1, 5'd1, 5'd2, 5'd3, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        n_vec++;
        if (out_valid !== 1'b0 || fl_count !== 7'd32 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset: got valid=%b count=%0d ready=%b expected 0 32 1",
                     out_valid, fl_count, in_ready);
        end
        n_vec++;
        if ({out_prs1, out_prs2, out_prd, out_prd_old, out_pc} !== 56'd0) begin
            n_err++;
            $display("FAIL mid_reset_outs: got %h expected 0",
                     {out_prs1, out_prs2, out_prd, out_prd_old, out_pc});
        end
        for (int k = 0; k < 16; k++) begin
            set_in(1'b1, 5'(2 * k), 5'(2 * k + 1), 5'd0, 1'b0);
            tick();
            n_vec++;
            if (out_prs1 !== 6'(2 * k) || out_prs2 !== 6'(2 * k + 1)) begin
                n_err++;
                $display("FAIL rat_identity: got %0d %0d expected %0d %0d",
                         out_prs1, out_prs2, 2 * k, 2 * k + 1);
            end
        end
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        tick();
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_rs1     = '0;
        in_rs2     = '0;
        in_rd      = '0;
        in_wr      = 1'b0;
        in_pc      = '0;
        out_ready  = 1'b1;
        free_valid = 1'b0;
        free_tag   = '0;
        last_xfer  = 1'b0;
        test_reset();
        test_basic();
        test_fill();
        test_empty_free();
        test_hold();
        test_wrap();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rename_unit.md
# rename_unit

Register-rename stage directly upstream of the ROB. Each cycle it accepts one decoded instruction (architectural rs1/rs2/rd plus PC), maps sources through the register alias table (RAT), allocates a fresh physical destination from a circular free list, and presents `{prd, prd_old, pc}` to the ROB allocation port. Physical tags freed by ROB retirement return through the free port.

## Interface
- `ARCH_REGS`, 32, architectural register count (x0..x31)
- `PHYS_REGS`, 64, physical register count; tags are 6 bits
- `clk` input 1 clock; all state updates on posedge
- `reset` input 1 synchronous, active-high reset
- `in_valid` input 1 decoded instruction present
- `in_ready` output 1 stage can accept this cycle
- `in_rs1`, `in_rs2` input 5 each; architectural sources
- `in_rd` input 5 architectural destination
- `in_wr` input 1 instruction writes `in_rd`
- `in_pc` input 32 instruction PC
- `out_valid` output 1 renamed instruction held for ROB
- `out_ready` input 1 ROB accepts this cycle
- `out_prs1`, `out_prs2` output 6 each; physical sources
- `out_prd` output 6 new physical destination (0 if none)
- `out_prd_old` output 6 previous mapping of `in_rd` (0 if none)
- `out_pc` output 32 registered PC
- `free_valid` input 1 ROB retirement returns a tag
- `free_tag` input 6 tag being freed
- `fl_count` output 7 free-list occupancy (0..64)

## Operation
- RAT: 32 x 6-bit. Reset: RAT[i] = i. Free list: 64-entry circular FIFO, 6-bit head/tail, 7-bit count; reset contents tags 32..63 at slots 0..31, head=0, tail=32, count=32.
- Allocation needed (`alloc`) iff transfer and `in_wr` and `in_rd != 0`.
- Transfer: `in_valid && in_ready`. `in_ready = (!out_valid || out_ready) && (count != 0 || !(in_wr && in_rd != 0))`; i.e. stall only when this instruction needs a tag and list is empty.
- On transfer: `out_prs1 = RAT[in_rs1]`, `out_prs2 = RAT[in_rs2]` (x0 always maps to 0); if alloc: `out_prd = FL[head]`, `out_prd_old = RAT[in_rd]`, `RAT[in_rd] <= FL[head]`, head+1 mod 64; else `out_prd = 0`, `out_prd_old = 0`. `out_pc = in_pc`, `out_valid <= 1`.
- No transfer and `out_ready`: `out_valid <= 0`. `out_valid && !out_ready`: all out_* held stable.
- Free: `free_valid && free_tag != 0` writes FL[tail], tail+1 mod 64. `free_tag == 0` ignored.
- count next = count + free_accepted - alloc; simultaneous free and alloc leaves count unchanged.
- Back-to-back instructions: RAT write and next read are separated by one edge, so consecutive dependent instructions see the updated mapping; no intra-cycle bypass needed.
- Caller guarantees no free when count == 64 and no double free; behaviour then undefined.

## Timing
- Latency 1 cycle: instruction accepted at edge N is on out_* after edge N.
- Reset values: `out_valid=0`, `out_prs1/prs2/prd/prd_old=0`, `out_pc=0`, `fl_count=32`; `in_ready=1` after reset.
- Reset mid-stall discards held output and restores initial RAT/free list in same edge.
- Free-list wrap: head/tail wrap 63->0 without gap.
- `in_ready` is combinational from `out_valid`, `out_ready`, `count`, `in_wr`, `in_rd`.

## Configuration
- `RENAME_FREE_BYPASS_EN` defined: when count == 0 and `free_valid && free_tag != 0` in the same cycle, `in_ready` may assert for an allocating instruction; the allocation uses `free_tag` directly, FL is not written, head/tail/count unchanged.
- Undefined: empty list stalls allocating instructions regardless of a same-cycle free; the freed tag is enqueued and usable next cycle.

## Test plan
- Reset, rename `add x5,x1,x2` (rd=5) -> next cycle out_prs1=1, out_prs2=2, out_prd=32, out_prd_old=5, fl_count=31.
- Follow with `add x6,x5,x5` back-to-back -> out_prs1=out_prs2=32, out_prd=33, out_prd_old=6.
- Rename 32 writes with no frees -> fl_count=0, 33rd allocating instruction sees in_ready=0; a non-writing or rd=0 instruction still transfers with out_prd=0.
- At count=0, free tag 5 with allocating instruction pending -> without macro: stall one cycle, then out_prd=5; with macro: transfer same cycle, out_prd=5, fl_count stays 0.
- Hold out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0, no RAT/free-list change; release -> next instruction transfers.
- Drive 70 alloc/free pairs to wrap head/tail past 63 -> tags return in FIFO order, fl_count constant; assert reset mid-sequence -> RAT[i]=i, fl_count=32, out_valid=0.
